// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - execute/fetch-side signal bundle for pc_sequencer (PC_SEQ_INSTRET_EN adds o_instret)
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic [1:0]      i_prePCSrc;
    logic [XLEN-1:0] i_branchTarget;
    logic [XLEN-1:0] i_jalrTarget;
    logic [XLEN-1:0] i_mtvec;
    logic            i_instDone;
    logic            i_stall;
    logic            i_imemReady;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pcPlus4;
    logic            o_imemReq;
    logic            o_fetched;
    logic            o_trapTaken;
    logic [XLEN-1:0] o_mepc;
    logic [3:0]      o_mcause;
`ifdef PC_SEQ_INSTRET_EN
    logic [63:0]     o_instret;

    modport master (
        output i_prePCSrc, i_branchTarget, i_jalrTarget, i_mtvec,
               i_instDone, i_stall, i_imemReady,
        input  o_pc, o_pcPlus4, o_imemReq, o_fetched, o_trapTaken,
               o_mepc, o_mcause, o_instret
    );
    modport slave (
        input  i_prePCSrc, i_branchTarget, i_jalrTarget, i_mtvec,
               i_instDone, i_stall, i_imemReady,
        output o_pc, o_pcPlus4, o_imemReq, o_fetched, o_trapTaken,
               o_mepc, o_mcause, o_instret
    );
`else
    modport master (
        output i_prePCSrc, i_branchTarget, i_jalrTarget, i_mtvec,
               i_instDone, i_stall, i_imemReady,
        input  o_pc, o_pcPlus4, o_imemReq, o_fetched, o_trapTaken,
               o_mepc, o_mcause
    );
    modport slave (
        input  i_prePCSrc, i_branchTarget, i_jalrTarget, i_mtvec,
               i_instDone, i_stall, i_imemReady,
        output o_pc, o_pcPlus4, o_imemReq, o_fetched, o_trapTaken,
               o_mepc, o_mcause
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - RV32I PC register, fetch handshake and trap capture; PC_SEQ_INSTRET_EN adds a retired-instruction counter
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic          i_clk,
    input logic          i_rst,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {HOLD, FETCH, EXEC} state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q, mepc_q;
    logic [3:0]      mcause_q;
    logic            imem_req_q, fetched_q, trap_taken_q;
`ifdef PC_SEQ_INSTRET_EN
    logic [63:0]     instret_q;
`endif

    logic [XLEN-1:0] pc_plus4, target, pc_d;
    logic [3:0]      mcause_d;
    logic            misaligned, trap_d, commit;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign commit   = (state_q == EXEC) && bus.i_instDone && !bus.i_stall;

    always_comb begin
        target = pc_plus4;
        case (bus.i_prePCSrc)
            2'b01:   target = bus.i_branchTarget;
            2'b11:   target = {bus.i_jalrTarget[XLEN-1:1], 1'b0};
            default: target = pc_plus4;
        endcase
        // Only redirecting codes can misalign; PC+4 from an aligned PC never does.
        misaligned = bus.i_prePCSrc[0] && target[1];
        trap_d     = (bus.i_prePCSrc == 2'b10) || misaligned;
        mcause_d   = (bus.i_prePCSrc == 2'b10) ? 4'd11 : 4'd0;
        pc_d       = trap_d ? {bus.i_mtvec[XLEN-1:2], 2'b00} : target;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= HOLD;
            pc_q         <= RESET_PC;
            mepc_q       <= '0;
            mcause_q     <= 4'd0;
            imem_req_q   <= 1'b0;
            fetched_q    <= 1'b0;
            trap_taken_q <= 1'b0;
`ifdef PC_SEQ_INSTRET_EN
            instret_q    <= 64'd0;
`endif
        end else begin
            fetched_q    <= 1'b0;
            trap_taken_q <= 1'b0;
            case (state_q)
                HOLD: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.i_imemReady) begin
                        state_q    <= EXEC;
                        imem_req_q <= 1'b0;
                        fetched_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                        pc_q       <= pc_d;
                        if (trap_d) begin
                            mepc_q       <= pc_q;
                            mcause_q     <= mcause_d;
                            trap_taken_q <= 1'b1;
                        end
`ifdef PC_SEQ_INSTRET_EN
                        else begin
                            instret_q <= instret_q + 64'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_q    <= HOLD;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pc        = pc_q;
    assign bus.o_pcPlus4   = pc_plus4;
    assign bus.o_imemReq   = imem_req_q;
    assign bus.o_fetched   = fetched_q;
    assign bus.o_trapTaken = trap_taken_q;
    assign bus.o_mepc      = mepc_q;
    assign bus.o_mcause    = mcause_q;
`ifdef PC_SEQ_INSTRET_EN
    assign bus.o_instret   = instret_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector bench for pc_sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [63:0] exp_instret = 64'd0;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_1000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [1:0] code, input logic [31:0] btgt, input logic [31:0] jtgt);
        bus.i_imemReady = 1'b1;
        step();
        bus.i_imemReady    = 1'b0;
        bus.i_instDone     = 1'b1;
        bus.i_prePCSrc     = code;
        bus.i_branchTarget = btgt;
        bus.i_jalrTarget   = jtgt;
        step();
        bus.i_instDone = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_prePCSrc = 2'b00; bus.i_branchTarget = '0; bus.i_jalrTarget = '0;
        bus.i_mtvec = 32'h0000_0507; bus.i_instDone = 1'b0; bus.i_stall = 1'b0; bus.i_imemReady = 1'b1;
        step(); step();
        vecs++; if (bus.o_pc !== 32'h1000) begin errs++; $display("FAIL reset_pc got %h want 00001000", bus.o_pc); end
        vecs++; if (bus.o_pcPlus4 !== 32'h1004) begin errs++; $display("FAIL reset_pcplus4 got %h want 00001004", bus.o_pcPlus4); end
        vecs++; if ({bus.o_imemReq, bus.o_fetched, bus.o_trapTaken} !== 3'b000) begin errs++; $display("FAIL reset_pulses got %b want 000", {bus.o_imemReq, bus.o_fetched, bus.o_trapTaken}); end
        vecs++; if (bus.o_mepc !== 32'h0 || bus.o_mcause !== 4'd0) begin errs++; $display("FAIL reset_trapregs got %h/%0d want 0/0", bus.o_mepc, bus.o_mcause); end
`ifdef PC_SEQ_INSTRET_EN
        vecs++; if (bus.o_instret !== 64'd0) begin errs++; $display("FAIL reset_instret got %0d want 0", bus.o_instret); end
`endif
        rst = 1'b0;
        step();
        vecs++; if (bus.o_imemReq !== 1'b1 || bus.o_pc !== 32'h1000) begin errs++; $display("FAIL first_req got req=%b pc=%h want 1/00001000", bus.o_imemReq, bus.o_pc); end
        step();
        vecs++; if (bus.o_fetched !== 1'b1 || bus.o_imemReq !== 1'b0) begin errs++; $display("FAIL first_fetch got fetched=%b req=%b want 1/0", bus.o_fetched, bus.o_imemReq); end
        bus.i_imemReady = 1'b0; bus.i_instDone = 1'b1; bus.i_prePCSrc = 2'b00;
        step();
        bus.i_instDone = 1'b0;
        exp_instret++;
        vecs++; if (bus.o_pc !== 32'h1004 || bus.o_imemReq !== 1'b1 || bus.o_fetched !== 1'b0) begin errs++; $display("FAIL commit_pc4 got pc=%h req=%b want 00001004/1", bus.o_pc, bus.o_imemReq); end
    endtask

    task automatic test_fetch_wait();
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++; if (bus.o_imemReq !== 1'b1 || bus.o_pc !== 32'h1004 || bus.o_fetched !== 1'b0) begin errs++; $display("FAIL fetch_wait%0d got req=%b pc=%h fetched=%b want 1/00001004/0", i, bus.o_imemReq, bus.o_pc, bus.o_fetched); end
        end
        bus.i_imemReady = 1'b1;
        step();
        bus.i_imemReady = 1'b0;
        vecs++; if (bus.o_fetched !== 1'b1 || bus.o_imemReq !== 1'b0) begin errs++; $display("FAIL fetch_ready got fetched=%b req=%b want 1/0", bus.o_fetched, bus.o_imemReq); end
        bus.i_imemReady = 1'b1;
        step();
        bus.i_imemReady = 1'b0;
        vecs++; if (bus.o_fetched !== 1'b0 || bus.o_imemReq !== 1'b0) begin errs++; $display("FAIL fetch_pulse_once got fetched=%b req=%b want 0/0", bus.o_fetched, bus.o_imemReq); end
    endtask

    task automatic test_stall();
        bus.i_instDone = 1'b1; bus.i_stall = 1'b1; bus.i_prePCSrc = 2'b01; bus.i_branchTarget = 32'h2000;
        for (int i = 0; i < 2; i++) begin
            step();
            vecs++; if (bus.o_pc !== 32'h1004 || bus.o_imemReq !== 1'b0) begin errs++; $display("FAIL stall%0d got pc=%h req=%b want 00001004/0", i, bus.o_pc, bus.o_imemReq); end
        end
        bus.i_stall = 1'b0;
        step();
        bus.i_instDone = 1'b0;
        exp_instret++;
        vecs++; if (bus.o_pc !== 32'h2000 || bus.o_imemReq !== 1'b1 || bus.o_trapTaken !== 1'b0) begin errs++; $display("FAIL stall_branch got pc=%h req=%b trap=%b want 00002000/1/0", bus.o_pc, bus.o_imemReq, bus.o_trapTaken); end
    endtask

    task automatic test_misaligned();
        run_instr(2'b01, 32'h1010, 32'h0);
        exp_instret++;
        vecs++; if (bus.o_pc !== 32'h1010) begin errs++; $display("FAIL goto_1010 got %h want 00001010", bus.o_pc); end
        bus.i_mtvec = 32'h0000_0507;
        run_instr(2'b11, 32'h0, 32'h3003);
        vecs++; if (bus.o_pc !== 32'h504 || bus.o_trapTaken !== 1'b1) begin errs++; $display("FAIL misalign_pc got pc=%h trap=%b want 00000504/1", bus.o_pc, bus.o_trapTaken); end
        vecs++; if (bus.o_mepc !== 32'h1010 || bus.o_mcause !== 4'd0) begin errs++; $display("FAIL misalign_cause got %h/%0d want 00001010/0", bus.o_mepc, bus.o_mcause); end
        step();
        vecs++; if (bus.o_trapTaken !== 1'b0) begin errs++; $display("FAIL misalign_pulse got %b want 0", bus.o_trapTaken); end
`ifdef PC_SEQ_INSTRET_EN
        vecs++; if (bus.o_instret !== exp_instret) begin errs++; $display("FAIL misalign_instret got %0d want %0d", bus.o_instret, exp_instret); end
`endif
    endtask

    task automatic test_ecall();
        run_instr(2'b01, 32'h1020, 32'h0);
        exp_instret++;
        bus.i_mtvec = 32'h0000_0101;
        run_instr(2'b10, 32'h0, 32'h0);
        vecs++; if (bus.o_pc !== 32'h100 || bus.o_trapTaken !== 1'b1) begin errs++; $display("FAIL ecall_pc got pc=%h trap=%b want 00000100/1", bus.o_pc, bus.o_trapTaken); end
        vecs++; if (bus.o_mepc !== 32'h1020 || bus.o_mcause !== 4'd11) begin errs++; $display("FAIL ecall_cause got %h/%0d want 00001020/11", bus.o_mepc, bus.o_mcause); end
`ifdef PC_SEQ_INSTRET_EN
        vecs++; if (bus.o_instret !== exp_instret) begin errs++; $display("FAIL ecall_instret got %0d want %0d", bus.o_instret, exp_instret); end
`endif
    endtask

    task automatic test_jalr_and_wrap();
        run_instr(2'b11, 32'h0, 32'h3001);
        exp_instret++;
        vecs++; if (bus.o_pc !== 32'h3000 || bus.o_trapTaken !== 1'b0) begin errs++; $display("FAIL jalr_clear_bit0 got pc=%h trap=%b want 00003000/0", bus.o_pc, bus.o_trapTaken); end
        run_instr(2'b01, 32'hFFFF_FFFC, 32'h0);
        exp_instret++;
        vecs++; if (bus.o_pc !== 32'hFFFF_FFFC || bus.o_pcPlus4 !== 32'h0) begin errs++; $display("FAIL wrap_setup got pc=%h pc4=%h want fffffffc/00000000", bus.o_pc, bus.o_pcPlus4); end
        run_instr(2'b00, 32'h0, 32'h0);
        exp_instret++;
        vecs++; if (bus.o_pc !== 32'h0 || bus.o_trapTaken !== 1'b0) begin errs++; $display("FAIL wrap_pc got pc=%h trap=%b want 00000000/0", bus.o_pc, bus.o_trapTaken); end
        vecs++; if (bus.o_mepc !== 32'h1020 || bus.o_mcause !== 4'd11) begin errs++; $display("FAIL trapregs_hold got %h/%0d want 00001020/11", bus.o_mepc, bus.o_mcause); end
`ifdef PC_SEQ_INSTRET_EN
        vecs++; if (bus.o_instret !== exp_instret) begin errs++; $display("FAIL wrap_instret got %0d want %0d", bus.o_instret, exp_instret); end
`endif
    endtask

    task automatic test_reset_mid_exec();
        bus.i_imemReady = 1'b1;
        step();
        bus.i_imemReady = 1'b0; bus.i_instDone = 1'b1; bus.i_stall = 1'b1; bus.i_prePCSrc = 2'b00;
        rst = 1'b1;
        step();
        vecs++; if (bus.o_pc !== 32'h1000 || bus.o_imemReq !== 1'b0) begin errs++; $display("FAIL rst_exec_pc got pc=%h req=%b want 00001000/0", bus.o_pc, bus.o_imemReq); end
        vecs++; if (bus.o_mepc !== 32'h0 || bus.o_mcause !== 4'd0) begin errs++; $display("FAIL rst_exec_trapregs got %h/%0d want 0/0", bus.o_mepc, bus.o_mcause); end
        bus.i_instDone = 1'b0; bus.i_stall = 1'b0;
        step();
        rst = 1'b0;
        step();
        vecs++; if (bus.o_imemReq !== 1'b1 || bus.o_pc !== 32'h1000 || bus.o_fetched !== 1'b0) begin errs++; $display("FAIL rst_refetch got req=%b pc=%h fetched=%b want 1/00001000/0", bus.o_imemReq, bus.o_pc, bus.o_fetched); end
`ifdef PC_SEQ_INSTRET_EN
        vecs++; if (bus.o_instret !== 64'd0) begin errs++; $display("FAIL rst_instret got %0d want 0", bus.o_instret); end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_stall();
        test_misaligned();
        test_ecall();
        test_jalr_and_wrap();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
